// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared raster timing constants for 800x600 at 72 Hz
package vga_pkg;

  localparam int CNT_W = 11;

  typedef logic [CNT_W-1:0] count_t;

  function automatic int axis_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

  localparam int H_VISIBLE_DEF = 800;
  localparam int H_FRONT_DEF   = 56;
  localparam int H_SYNC_DEF    = 120;
  localparam int H_BACK_DEF    = 64;
  localparam int H_TOTAL_DEF   = axis_total(H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int H_SYNC_START  = H_VISIBLE_DEF + H_FRONT_DEF;
  localparam int H_SYNC_END    = H_SYNC_START + H_SYNC_DEF;

  localparam int V_VISIBLE_DEF = 600;
  localparam int V_FRONT_DEF   = 37;
  localparam int V_SYNC_DEF    = 6;
  localparam int V_BACK_DEF    = 23;
  localparam int V_TOTAL_DEF   = axis_total(V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);
  localparam int V_SYNC_START  = V_VISIBLE_DEF + V_FRONT_DEF;
  localparam int V_SYNC_END    = V_SYNC_START + V_SYNC_DEF;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping counter with registered sync/blank decode
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int VISIBLE = H_VISIBLE_DEF,
  parameter int FRONT   = H_FRONT_DEF,
  parameter int SYNC    = H_SYNC_DEF,
  parameter int BACK    = H_BACK_DEF,
  parameter bit POL     = 1'b1
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   en_i,
  output count_t count_o,
  output logic   sync_o,
  output logic   blank_axis_o,
  output logic   wrap_o
);

  localparam int     TOTAL      = axis_total(VISIBLE, FRONT, SYNC, BACK);
  localparam count_t LAST       = count_t'(TOTAL - 1);
  localparam count_t VIS_END    = count_t'(VISIBLE);
  localparam count_t SYNC_START = count_t'(VISIBLE + FRONT);
  localparam count_t SYNC_END   = count_t'(VISIBLE + FRONT + SYNC);

  // Declared initial values keep the outputs defined even if reset is never pulsed.
  count_t count_q = '0;
  logic   sync_q  = ~POL;
  logic   blank_q = 1'b0;
  count_t count_d;
  logic   sync_d;
  logic   blank_d;

  assign wrap_o = en_i && (count_q == LAST);

  // Decode from the next count so sync/blank line up with the count they accompany.
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + count_t'(1);
    end
    sync_d  = ((count_d >= SYNC_START) && (count_d < SYNC_END)) ? POL : ~POL;
    blank_d = (count_d >= VIS_END);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      sync_q  <= ~POL;
      blank_q <= 1'b0;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
      blank_q <= blank_d;
    end
  end

  assign count_o      = count_q;
  assign sync_o       = sync_q;
  assign blank_axis_o = blank_q;

endmodule

// File: rtl/vga.sv
// rtl/vga.sv - free-running VGA raster timing generator (default 800x600 at 72 Hz)
module vga
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1
) (
  input  logic             VGA_clock,
  input  logic             VGA_reset_n,
  output logic             HS,
  output logic             VS,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             blank
);

  logic h_wrap;
  logic v_wrap_unused;
  logic blank_h;
  logic blank_v;

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK),
    .POL    (HS_POL)
  ) u_h (
    .clk_i       (VGA_clock),
    .rst_ni      (VGA_reset_n),
    .en_i        (1'b1),
    .count_o     (hcount),
    .sync_o      (HS),
    .blank_axis_o(blank_h),
    .wrap_o      (h_wrap)
  );

  // The line wrap is the only event that advances the vertical axis.
  vga_axis_counter #(
    .VISIBLE(V_VISIBLE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK),
    .POL    (VS_POL)
  ) u_v (
    .clk_i       (VGA_clock),
    .rst_ni      (VGA_reset_n),
    .en_i        (h_wrap),
    .count_o     (vcount),
    .sync_o      (VS),
    .blank_axis_o(blank_v),
    .wrap_o      (v_wrap_unused)
  );

  assign blank = blank_h | blank_v;

endmodule

// File: tb/tb_vga.sv
// tb/tb_vga.sv - directed self-checking bench for the vga raster generator
module tb_vga;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst_s_n;
  logic        hs_b, vs_b, blank_b;
  logic [10:0] hc_b, vc_b;
  logic        hs_s, vs_s, blank_s;
  logic [10:0] hc_s, vc_s;

  int checks = 0;
  int failures = 0;

  always #10 clk = ~clk;

  vga u_big (
    .VGA_clock  (clk),
    .VGA_reset_n(rst_n),
    .HS         (hs_b),
    .VS         (vs_b),
    .hcount     (hc_b),
    .vcount     (vc_b),
    .blank      (blank_b)
  );

  // Tiny raster: H total 16 (HS active-low on 10..12), V total 12 (VS on 8..9).
  vga #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .HS_POL(1'b0), .VS_POL(1'b1)
  ) u_small (
    .VGA_clock  (clk),
    .VGA_reset_n(rst_s_n),
    .HS         (hs_s),
    .VS         (vs_s),
    .hcount     (hc_s),
    .vcount     (vc_s),
    .blank      (blank_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_big_reset(input string tag);
    check({tag, "_hcount"}, 32'(hc_b), 0);
    check({tag, "_vcount"}, 32'(vc_b), 0);
    check({tag, "_blank"}, 32'(blank_b), 0);
    check({tag, "_hs"}, 32'(hs_b), 0);
    check({tag, "_vs"}, 32'(vs_b), 0);
  endtask

  task automatic check_small_reset(input string tag);
    check({tag, "_hcount"}, 32'(hc_s), 0);
    check({tag, "_vcount"}, 32'(vc_s), 0);
    check({tag, "_blank"}, 32'(blank_s), 0);
    check({tag, "_hs"}, 32'(hs_s), 1);
    check({tag, "_vs"}, 32'(vs_s), 0);
  endtask

  initial begin
    int eh, ev;
    int err_h, err_v, err_b, err_hs, err_vs;
    int cnt_vs, cnt_blank, cnt_hs;
    int rise[4];
    int nrise;
    logic prev_hs;

    rst_n   = 1'b0;
    rst_s_n = 1'b1;
    #5;
    check_big_reset("big_reset");
    check_small_reset("small_init_noreset");

    // Small raster free-runs from time 0 without any reset pulse.
    err_h = 0; err_v = 0; err_b = 0; err_hs = 0; err_vs = 0;
    cnt_vs = 0; cnt_blank = 0; cnt_hs = 0;
    for (int t = 1; t <= 400; t++) begin
      step();
      eh = t % 16;
      ev = (t / 16) % 12;
      if (32'(hc_s) !== eh) err_h++;
      if (32'(vc_s) !== ev) err_v++;
      if (blank_s !== ((eh >= 8) || (ev >= 6))) err_b++;
      if (hs_s !== !((eh >= 10) && (eh < 13))) err_hs++;
      if (vs_s !== ((ev >= 8) && (ev < 10))) err_vs++;
      if (t >= 192 && t < 384) begin
        if (vs_s === 1'b1) cnt_vs++;
        if (blank_s === 1'b1) cnt_blank++;
        if (hs_s === 1'b0) cnt_hs++;
      end
      if (t == 191) begin
        check("small_last_h", 32'(hc_s), 15);
        check("small_last_v", 32'(vc_s), 11);
      end
      if (t == 192) begin
        check("small_frame_wrap_h", 32'(hc_s), 0);
        check("small_frame_wrap_v", 32'(vc_s), 0);
      end
    end
    check("small_err_hcount", err_h, 0);
    check("small_err_vcount", err_v, 0);
    check("small_err_blank", err_b, 0);
    check("small_err_hs", err_hs, 0);
    check("small_err_vs", err_vs, 0);
    check("small_vs_clocks", cnt_vs, 32);
    check("small_blank_clocks", cnt_blank, 144);
    check("small_hs_active_clocks", cnt_hs, 36);

    // Mid-frame asynchronous reset inside the small VS region (t=517 -> h=5, v=8).
    repeat (117) step();
    check("small_pre_rst_h", 32'(hc_s), 5);
    check("small_pre_rst_v", 32'(vc_s), 8);
    check("small_pre_rst_vs", 32'(vs_s), 1);
    check("small_pre_rst_blank", 32'(blank_s), 1);
    #5 rst_s_n = 1'b0;
    #1;
    check_small_reset("small_async_rst");
    repeat (2) step();
    rst_s_n = 1'b1;
    step();
    check("small_restart_h", 32'(hc_s), 1);
    check("small_restart_v", 32'(vc_s), 0);

    // Default raster: two lines plus a bit, checked every clock.
    check_big_reset("big_reset_held");
    rst_n = 1'b1;
    err_h = 0; err_v = 0; err_b = 0; err_hs = 0; err_vs = 0;
    cnt_hs = 0; nrise = 0; prev_hs = hs_b;
    for (int t = 1; t <= 2200; t++) begin
      step();
      eh = t % 1040;
      ev = t / 1040;
      if (32'(hc_b) !== eh) err_h++;
      if (32'(vc_b) !== ev) err_v++;
      if (blank_b !== (eh >= 800)) err_b++;
      if (hs_b !== ((eh >= 856) && (eh < 976))) err_hs++;
      if (vs_b !== 1'b0) err_vs++;
      if (t < 1040 && hs_b === 1'b1) cnt_hs++;
      if (prev_hs === 1'b0 && hs_b === 1'b1) begin
        if (nrise < 4) rise[nrise] = t;
        nrise++;
      end
      prev_hs = hs_b;
      if (t == 1) check("big_first_edge_h", 32'(hc_b), 1);
      if (t == 799) check("big_blank_799", 32'(blank_b), 0);
      if (t == 800) check("big_blank_800", 32'(blank_b), 1);
      if (t == 1040) begin
        check("big_line_wrap_h", 32'(hc_b), 0);
        check("big_line_wrap_v", 32'(vc_b), 1);
      end
    end
    check("big_err_hcount", err_h, 0);
    check("big_err_vcount", err_v, 0);
    check("big_err_blank", err_b, 0);
    check("big_err_hs", err_hs, 0);
    check("big_err_vs", err_vs, 0);
    check("big_hs_clocks", cnt_hs, 120);
    check("big_hs_rises", nrise, 2);
    if (nrise >= 2) begin
      check("big_hs_first_rise", rise[0], 856);
      check("big_hs_rise_period", rise[1] - rise[0], 1040);
    end

    // Mid-frame asynchronous reset at (500, 2).
    repeat (380) step();
    check("big_pre_rst_h", 32'(hc_b), 500);
    check("big_pre_rst_v", 32'(vc_b), 2);
    #5 rst_n = 1'b0;
    #1;
    check_big_reset("big_async_rst");
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("big_restart_h", 32'(hc_b), 1);
    check("big_restart_v", 32'(vc_b), 0);
    repeat (1039) step();
    check("big_restart_wrap_h", 32'(hc_b), 0);
    check("big_restart_wrap_v", 32'(vc_b), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
